// File: rtl/camo_pkg.sv
// camo_pkg: shared definitions for the camouflaged-gate key loader.
//   - CAMO_* : per-gate select codes {D[2i+1], D[2i]}
//   - state_t: loader FSM states
//   - key_w(): key word width (two select bits per camouflaged gate)
package camo_pkg;

    localparam logic [1:0] CAMO_PASS = 2'b00;
    localparam logic [1:0] CAMO_INV  = 2'b10;
    localparam logic [1:0] CAMO_ONE  = 2'b01;
    localparam logic [1:0] CAMO_ZERO = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        APPLY,
        LOCKED
    } state_t;

    function automatic int key_w(input int num_gates);
        return 2 * num_gates;
    endfunction

endpackage

// File: rtl/camo_key_loader_if.sv
// camo_key_loader_if: serial key stream from the configuration port.
//   key_valid : key_bit/key_last/lock_req valid this cycle (source)
//   key_ready : loader accepts a bit this cycle (loader)
//   key_bit   : serial key bit, D_0 first, parity bit last (source)
//   key_last  : final (parity) bit of a frame (source)
//   lock_req  : lock after a successful commit, sampled with key_last (source)
interface camo_key_loader_if;
    logic key_valid;
    logic key_ready;
    logic key_bit;
    logic key_last;
    logic lock_req;

    modport master (
        output key_valid, key_bit, key_last, lock_req,
        input  key_ready
    );

    modport slave (
        input  key_valid, key_bit, key_last, lock_req,
        output key_ready
    );
endinterface

// File: rtl/camo_shadow_reg.sv
// camo_shadow_reg: shadow register that collects a key frame bit by bit,
// plus the running even-parity accumulator over every bit of the frame.
//   clk    : clock
//   wr_en  : write bit_in at position idx and fold it into the parity
//   first  : this write starts a new frame (parity restarts from bit_in)
//   idx    : bit position; positions >= KEY_W (the parity bit) only affect parity
//   bit_in : serial bit
//   shadow : collected key word
//   parity : XOR of all bits written since the last first-write
module camo_shadow_reg #(
    parameter int KEY_W = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic             first,
    input  logic [CNT_W-1:0] idx,
    input  logic             bit_in,
    output logic [KEY_W-1:0] shadow,
    output logic             parity
);

    // Pure datapath: a new frame always starts with first=1, which
    // overwrites any stale content, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < KEY_W; i++) begin
                if (idx == CNT_W'(i)) begin
                    shadow[i] <= bit_in;
                end
            end
            parity <= first ? bit_in : (parity ^ bit_in);
        end
    end

endmodule

// File: rtl/camo_key_loader.sv
// camo_key_loader: receives a key bitstream, checks length and even parity,
// and commits the select codes to all camouflaged gates in one edge.
// Until a good frame is committed every gate is held at constant-0.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   key_if   : serial key stream (slave side)
//   D        : select codes, {D[2i+1], D[2i]} drives gate i
//   cfg_done : one-cycle pulse on a successful commit
//   cfg_err  : sticky frame error, cleared by the next accepted first bit
//   locked   : loader locked until reset
module camo_key_loader
    import camo_pkg::*;
#(
    parameter int NUM_GATES = 2,
    parameter int LOCKABLE  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    camo_key_loader_if.slave       key_if,
    output logic [2*NUM_GATES-1:0] D,
    output logic                   cfg_done,
    output logic                   cfg_err,
    output logic                   locked
);

    localparam int KEY_W = key_w(NUM_GATES);
    localparam int CNT_W = $clog2(KEY_W + 2);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(KEY_W + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             lock_lat, lock_lat_nxt;
    logic             err_nxt;
    logic             ready_int;
    logic             accept;
    logic             sh_wr, sh_first;
    logic             commit;
    logic [KEY_W-1:0] shadow;
    logic             parity;

    assign key_if.key_ready = ready_int & ~rst;
    assign accept           = key_if.key_valid & key_if.key_ready;

    camo_shadow_reg #(
        .KEY_W (KEY_W),
        .CNT_W (CNT_W)
    ) u_shadow (
        .clk    (clk),
        .wr_en  (sh_wr),
        .first  (sh_first),
        .idx    (count),
        .bit_in (key_if.key_bit),
        .shadow (shadow),
        .parity (parity)
    );

    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        lock_lat_nxt = lock_lat;
        err_nxt      = cfg_err;
        ready_int    = 1'b0;
        sh_wr        = 1'b0;
        sh_first     = 1'b0;
        commit       = 1'b0;
        case (state)
            IDLE: begin
                ready_int = 1'b1;
                if (accept) begin
                    sh_wr        = 1'b1;
                    sh_first     = 1'b1;
                    count_nxt    = CNT_W'(1);
                    err_nxt      = 1'b0;
                    lock_lat_nxt = key_if.key_last & key_if.lock_req;
                    state_nxt    = key_if.key_last ? CHECK : SHIFT;
                end
            end
            SHIFT: begin
                ready_int = 1'b1;
                if (accept) begin
                    if (count == FULL) begin
                        // Frame already complete: either a late key_last
                        // (forced to fail in CHECK by clearing count) or an
                        // overlength bit that aborts the frame immediately.
                        count_nxt = '0;
                        if (key_if.key_last) begin
                            lock_lat_nxt = key_if.lock_req;
                            state_nxt    = CHECK;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        sh_wr     = 1'b1;
                        count_nxt = count + CNT_W'(1);
                        if (key_if.key_last) begin
                            lock_lat_nxt = key_if.lock_req;
                            state_nxt    = CHECK;
                        end
                    end
                end
            end
            CHECK: begin
                count_nxt = '0;
                if (count == FULL && !parity) begin
                    commit    = 1'b1;
                    state_nxt = APPLY;
                end else begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            APPLY: begin
                state_nxt = (LOCKABLE != 0 && lock_lat) ? LOCKED : IDLE;
            end
            LOCKED: begin
                state_nxt = LOCKED;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // D, cfg_done and locked are loaded on the CHECK->APPLY edge so they
    // all change together in the APPLY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            lock_lat <= 1'b0;
            cfg_err  <= 1'b0;
            cfg_done <= 1'b0;
            locked   <= 1'b0;
            D        <= {NUM_GATES{CAMO_ZERO}};
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            lock_lat <= lock_lat_nxt;
            cfg_err  <= err_nxt;
            cfg_done <= commit;
            if (commit) begin
                D <= shadow;
                if (LOCKABLE != 0 && lock_lat) begin
                    locked <= 1'b1;
                end
            end
        end
    end

endmodule
